// File: rtl/cmd_decoder.sv
// DDR4 command-pin decoder: turns sampled pins into a registered one-hot command vector and sequences RD/WR bursts beat by beat.
// Optional macro BURST_CHOP_EN: RD/WR with a_in[12]=0 runs a 4-beat chopped burst.
module cmd_decoder #(
    parameter int ADDRWIDTH     = 17,
    parameter int BANKGROUPS    = 2,
    parameter int BANKSPERGROUP = 2,
    parameter int COLS          = 1024,
    parameter int BL            = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 cs_n,
    input  logic                                 act_n,
    input  logic                                 ras_n,
    input  logic                                 cas_n,
    input  logic                                 we_n,
    input  logic [ADDRWIDTH-1:0]                 a_in,
    input  logic [$clog2(BANKGROUPS):0]          bg_in,
    input  logic [$clog2(BANKSPERGROUP):0]       ba_in,
    input  logic                                 halt,
    output logic [18:0]                          commands,
    output logic [$clog2(BANKGROUPS):0]          bg,
    output logic [$clog2(BANKSPERGROUP):0]       ba,
    output logic [ADDRWIDTH-1:0]                 row,
    output logic [$clog2(COLS)-1:0]              column,
    output logic                                 burst_busy,
    output logic                                 cmd_err
);

    // state | meaning
    // IDLE  | no burst running; any decoded command is accepted
    // BURST | RD/WR beats in progress; only RD/WR on the last beat is accepted
    typedef enum logic [0:0] {IDLE, BURST} state_t;

    localparam int CW    = $clog2(COLS);
    localparam int BEATW = $clog2(BL);

    state_t                       state_q, state_d;
    logic [BEATW-1:0]             beat_q, beat_d;
    logic                         chop_q, chop_d;
    logic [18:0]                  commands_q, commands_d;
    logic [$clog2(BANKGROUPS):0]  bg_q, bg_d;
    logic [$clog2(BANKSPERGROUP):0] ba_q, ba_d;
    logic [ADDRWIDTH-1:0]         row_q, row_d;
    logic [CW-1:0]                column_q, column_d;
    logic                         busy_q, busy_d;
    logic                         err_q, err_d;

    logic [18:0]                  dec_cmd;
    logic                         dec_burst;
    logic                         dec_rsvd;
    logic                         dec_act;
    logic                         dec_valid;
    logic                         dec_chop;
    logic                         last_beat;
    logic [CW-1:0]                wrap_mask;

    always_comb begin
        dec_cmd   = '0;
        dec_burst = 1'b0;
        dec_rsvd  = 1'b0;
        dec_act   = 1'b0;
        if (!cs_n) begin
            if (!act_n) begin
                dec_cmd[18] = 1'b1;
                dec_act     = 1'b1;
            end else begin
                unique case ({ras_n, cas_n, we_n})
                    3'b010: begin
                        dec_cmd[8] = a_in[10];
                        dec_cmd[7] = ~a_in[10];
                    end
                    3'b101: begin
                        dec_cmd[4] = a_in[10];
                        dec_cmd[5] = ~a_in[10];
                        dec_burst  = 1'b1;
                    end
                    3'b100: begin
                        dec_cmd[0] = a_in[10];
                        dec_cmd[1] = ~a_in[10];
                        dec_burst  = 1'b1;
                    end
                    3'b001:  dec_cmd[10] = 1'b1;
                    3'b000:  dec_cmd[13] = 1'b1;
                    3'b111:  dec_rsvd    = 1'b0;
                    default: dec_rsvd    = 1'b1;
                endcase
            end
        end
        dec_valid = (dec_cmd != '0) || dec_rsvd;
    end

`ifdef BURST_CHOP_EN
    assign dec_chop = ~a_in[12];
`else
    assign dec_chop = 1'b0;
`endif

    // Beats wrap inside an N-aligned column block, so only the low log2(N) bits advance.
    assign wrap_mask = chop_q ? CW'(3) : CW'(BL - 1);
    assign last_beat = (beat_q == (chop_q ? BEATW'(3) : BEATW'(BL - 1)));

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        chop_d     = chop_q;
        commands_d = commands_q;
        bg_d       = bg_q;
        ba_d       = ba_q;
        row_d      = row_q;
        column_d   = column_q;
        busy_d     = busy_q;
        err_d      = err_q;
        if (!halt) begin
            if (state_q == IDLE || last_beat) begin
                state_d    = IDLE;
                beat_d     = '0;
                commands_d = '0;
                busy_d     = 1'b0;
                if (dec_burst) begin
                    state_d    = BURST;
                    chop_d     = dec_chop;
                    commands_d = dec_cmd;
                    busy_d     = 1'b1;
                    bg_d       = bg_in;
                    ba_d       = ba_in;
                    column_d   = a_in[CW-1:0];
                end else if (dec_valid && state_q == BURST) begin
                    err_d = 1'b1;
                end else if (dec_rsvd) begin
                    err_d = 1'b1;
                end else if (dec_valid) begin
                    commands_d = dec_cmd;
                    bg_d       = bg_in;
                    ba_d       = ba_in;
                    if (dec_act) begin
                        row_d = a_in;
                    end
                end
            end else begin
                beat_d   = beat_q + 1'b1;
                column_d = (column_q & ~wrap_mask) | ((column_q + CW'(1)) & wrap_mask);
                if (dec_valid) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            chop_q     <= 1'b0;
            commands_q <= '0;
            bg_q       <= '0;
            ba_q       <= '0;
            row_q      <= '0;
            column_q   <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            chop_q     <= chop_d;
            commands_q <= commands_d;
            bg_q       <= bg_d;
            ba_q       <= ba_d;
            row_q      <= row_d;
            column_q   <= column_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign commands   = commands_q;
    assign bg         = bg_q;
    assign ba         = ba_q;
    assign row        = row_q;
    assign column     = column_q;
    assign burst_busy = busy_q;
    assign cmd_err    = err_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder: command pulses, burst column wrap, halt stall, back-to-back bursts, async reset, burst chop.
module tb_cmd_decoder;

    logic        clk;
    logic        reset_n;
    logic        cs_n, act_n, ras_n, cas_n, we_n;
    logic [16:0] a_in;
    logic [1:0]  bg_in, ba_in;
    logic        halt;
    logic [18:0] commands;
    logic [1:0]  bg, ba;
    logic [16:0] row;
    logic [9:0]  column;
    logic        burst_busy;
    logic        cmd_err;

    int n_checks;
    int n_errors;

    cmd_decoder dut (
        .clk(clk), .reset_n(reset_n),
        .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .a_in(a_in), .bg_in(bg_in), .ba_in(ba_in), .halt(halt),
        .commands(commands), .bg(bg), .ba(ba), .row(row), .column(column),
        .burst_busy(burst_busy), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pins(input logic cs, input logic act, input logic ras, input logic cas,
                        input logic we, input logic [16:0] a, input logic [1:0] g, input logic [1:0] b);
        cs_n = cs; act_n = act; ras_n = ras; cas_n = cas; we_n = we;
        a_in = a; bg_in = g; ba_in = b;
    endtask

    task automatic nop();
        pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 17'd0, 2'd0, 2'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        halt     = 1'b0;
        nop();
        #12;
        check_val("rst_commands", commands, 0);
        check_val("rst_busy", burst_busy, 0);
        check_val("rst_err", cmd_err, 0);
        check_val("rst_column", column, 0);
        check_val("rst_row", row, 0);
        step();
        reset_n = 1'b1;

        // ACT pulse
        pins(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 17'd1, 2'd1, 2'd0);
        step();
        check_val("act_cmd", commands, 19'h40000);
        check_val("act_row", row, 1);
        check_val("act_bg", bg, 1);
        check_val("act_ba", ba, 0);
        nop();
        step();
        check_val("act_pulse_end", commands, 0);
        check_val("act_row_hold", row, 1);

        // Non-burst pulses: PRA, PR, REF, MRS
        pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 17'h00400, 2'd0, 2'd1);
        step();
        check_val("pra_cmd", commands, 19'h00100);
        check_val("pra_ba", ba, 1);
        pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 17'h00000, 2'd0, 2'd0);
        step();
        check_val("pr_cmd", commands, 19'h00080);
        pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17'h00000, 2'd0, 2'd0);
        step();
        check_val("ref_cmd", commands, 19'h00400);
        pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'h00000, 2'd0, 2'd0);
        step();
        check_val("mrs_cmd", commands, 19'h02000);
        nop();
        step();
        check_val("mrs_pulse_end", commands, 0);

        // WR, column 1: beats 1..7,0
        pins(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'd1, 2'd1, 2'd1);
        step();
        nop();
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("wr_cmd_b%0d", i), commands, 19'h00002);
            check_val($sformatf("wr_col_b%0d", i), column, (1 + i) % 8);
            check_val($sformatf("wr_busy_b%0d", i), burst_busy, 1);
            check_val($sformatf("wr_bg_b%0d", i), bg, 1);
            step();
        end
        check_val("wr_end_cmd", commands, 0);
        check_val("wr_end_busy", burst_busy, 0);
        check_val("wr_end_err", cmd_err, 0);

        // RD column 13 with 3-cycle halt at beat 2; ACT pins during halt must be ignored
        pins(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 17'd13, 2'd0, 2'd0);
        step();
        nop();
        for (int c = 0; c < 11; c++) begin
            int beat;
            beat = (c < 2) ? c : ((c <= 5) ? 2 : c - 3);
            check_val($sformatf("rdh_cmd_c%0d", c), commands, 19'h00020);
            check_val($sformatf("rdh_col_c%0d", c), column, 8 + ((5 + beat) % 8));
            check_val($sformatf("rdh_busy_c%0d", c), burst_busy, 1);
            halt = (c >= 2 && c <= 4);
            if (halt) pins(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 17'd7, 2'd0, 2'd0);
            else nop();
            step();
        end
        halt = 1'b0;
        nop();
        check_val("rdh_end_cmd", commands, 0);
        check_val("rdh_end_busy", burst_busy, 0);
        check_val("rdh_err", cmd_err, 0);
        check_val("rdh_row_kept", row, 1);

        // RD column 32; PR at beat 4 -> error; RD at last beat -> back-to-back burst at column 3
        pins(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 17'd32, 2'd0, 2'd0);
        step();
        for (int c = 0; c < 8; c++) begin
            check_val($sformatf("b2b1_cmd_c%0d", c), commands, 19'h00020);
            check_val($sformatf("b2b1_col_c%0d", c), column, 32 + c);
            check_val($sformatf("b2b1_err_c%0d", c), cmd_err, (c >= 5) ? 1 : 0);
            if (c == 4) pins(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 17'd0, 2'd0, 2'd0);
            else if (c == 7) pins(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 17'd3, 2'd1, 2'd0);
            else nop();
            step();
        end
        nop();
        for (int c = 0; c < 8; c++) begin
            check_val($sformatf("b2b2_cmd_c%0d", c), commands, 19'h00020);
            check_val($sformatf("b2b2_col_c%0d", c), column, (3 + c) % 8);
            check_val($sformatf("b2b2_busy_c%0d", c), burst_busy, 1);
            check_val($sformatf("b2b2_bg_c%0d", c), bg, 1);
            step();
        end
        check_val("b2b_end_cmd", commands, 0);
        check_val("b2b_err_sticky", cmd_err, 1);

        // WRA column 2, async reset at beat 3
        pins(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h00402, 2'd0, 2'd0);
        step();
        nop();
        check_val("wra_cmd", commands, 19'h00001);
        step();
        step();
        step();
        check_val("wra_b3_col", column, 5);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_cmd", commands, 0);
        check_val("arst_busy", burst_busy, 0);
        check_val("arst_err", cmd_err, 0);
        check_val("arst_col", column, 0);
        step();
        reset_n = 1'b1;
        pins(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 17'd9, 2'd0, 2'd1);
        step();
        check_val("post_rst_act", commands, 19'h40000);
        check_val("post_rst_row", row, 9);
        nop();
        step();

        // RD column 6 with a_in[12]=0
        pins(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 17'd6, 2'd0, 2'd0);
        step();
        nop();
`ifdef BURST_CHOP_EN
        for (int c = 0; c < 4; c++) begin
            check_val($sformatf("chop_col_c%0d", c), column, 4 + ((2 + c) % 4));
            check_val($sformatf("chop_busy_c%0d", c), burst_busy, 1);
            step();
        end
`else
        for (int c = 0; c < 8; c++) begin
            check_val($sformatf("nochop_col_c%0d", c), column, (6 + c) % 8);
            check_val($sformatf("nochop_busy_c%0d", c), burst_busy, 1);
            step();
        end
`endif
        check_val("chop_end_busy", burst_busy, 0);
        check_val("chop_end_cmd", commands, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
